// File: rtl/mdu_ctrl_if.sv
// Execute-stage <-> multiply/divide controller request/response bundle.
// The pipeline side is the master; the MDU controller is the slave.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic        stall;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs, rt,
        input  busy, stall, rdata, hi, lo
    );

    modport slave (
        input  start, op, rs, rt,
        output busy, stall, rdata, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: computes the 64-bit result at issue, then holds busy for a
// fixed countdown before committing it to the HI/LO architectural registers.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_ctrl_if.slave  bus
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMthi = 3'd4;
    localparam logic [2:0] OpMtlo = 3'd5;
    localparam logic [2:0] OpMfhi = 3'd6;
    localparam logic [2:0] OpMflo = 3'd7;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;
    logic            pend_wr_q, pend_wr_d;

    // Arithmetic datapath, evaluated on the issue cycle.
    logic        is_div, is_signed, div_zero;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] abs_a, abs_b, divisor, uq, ur, quo, rem;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        is_div    = bus.op[1];
        is_signed = ~bus.op[0];
        div_zero  = (bus.rt == 32'd0);

        // Sign-extended operands give the correct low 64 bits for both signednesses.
        mul_a = {{32{is_signed & bus.rs[31]}}, bus.rs};
        mul_b = {{32{is_signed & bus.rt[31]}}, bus.rt};
        prod  = mul_a * mul_b;

        abs_a   = (is_signed && bus.rs[31]) ? (32'd0 - bus.rs) : bus.rs;
        abs_b   = (is_signed && bus.rt[31]) ? (32'd0 - bus.rt) : bus.rt;
        divisor = div_zero ? 32'd1 : abs_b;
        uq      = abs_a / divisor;
        ur      = abs_a % divisor;
        // Truncating division: quotient negated when signs differ, remainder follows dividend.
        quo = (is_signed && (bus.rs[31] ^ bus.rt[31])) ? (32'd0 - uq) : uq;
        rem = (is_signed && bus.rs[31]) ? (32'd0 - ur) : ur;

        if (is_div) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.op)
                        OpMthi: hi_d = bus.rs;
                        OpMtlo: lo_d = bus.rs;
                        OpMfhi, OpMflo: ;
                        default: begin
                            pend_hi_d = res_hi;
                            pend_lo_d = res_lo;
                            pend_wr_d = ~(is_div & div_zero);
                            cnt_d     = is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                            state_d   = StRun;
                        end
                    endcase
                end
            end
            StRun: begin
                if (cnt_q == CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        bus.busy  = (state_q == StRun);
        bus.stall = bus.start & bus.busy;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
        case (bus.op)
            OpMfhi:  bus.rdata = hi_q;
            OpMflo:  bus.rdata = lo_q;
            default: bus.rdata = 32'd0;
        endcase
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide controller for the pipelined MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the execute stage and sequences the multi-cycle operation with a countdown counter.
- Owns the HI/LO architectural registers.
- Drives the busy/stall signal the hazard unit uses to freeze the pipeline.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, cycles busy is held for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request valid this cycle.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MFHI 7=MFLO.
- rs  input  32  operand A; dividend; MTHI/MTLO source.
- rt  input  32  operand B; divisor.
- busy  output  1  registered; high while a MULT/DIV is in progress.
- stall  output  1  combinational; high when the pipeline must hold this request.
- rdata  output  32  combinational; HI for op=6, LO for op=7, else 0.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, busy=0.
  - HI=0, LO=0, internal result latches=0.
  - An operation in flight is discarded with no HI/LO update.
- States: IDLE, RUN.
- IDLE, start=1, op in 0..3:
  - Latch the full 64-bit result into the pending registers at this edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
- RUN:
  - Counter decrements each cycle.
  - When counter reaches 1: at that edge HI/LO take the pending result, state goes to IDLE, busy goes to 0.
  - busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles after the start edge.
  - HI/LO are visible on the edge that clears busy.
- Arithmetic:
  - MULT: {HI,LO} = signed(rs) * signed(rt), 64-bit product.
  - MULTU: {HI,LO} = unsigned(rs) * unsigned(rt), 64-bit product.
  - DIV: LO = quotient, HI = remainder; truncate toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (rt=0): operation runs its full DIV_CYCLES, then HI/LO are left unchanged.
- MTHI/MTLO in IDLE:
  - HI (or LO) = rs at the start edge; zero latency; busy stays 0.
- MFHI/MFLO:
  - Purely combinational read of the current HI/LO; no state change.
- stall = start & (busy | (state==IDLE & op<=3 is not the case)) is not used; defined as follows:
  - stall = start & busy: any MDU request while busy is held.
  - start with op<=3 in IDLE is accepted, not stalled.
  - The pipeline must re-present a held request unchanged until stall=0.
- Requests while busy=1 are ignored by the controller. No queueing; the hazard unit guarantees re-issue.
- Simultaneous completion edge and a new start: start is still stalled that cycle (busy=1). It is accepted the following cycle.
- start=0: no state change except the RUN countdown.
- Undefined op values do not exist (3-bit op is fully decoded).

Test Plan:
- Reset pulse mid-DIV (reset=0 during the 4th RUN cycle) -> busy=0, HI=LO=0 immediately, no later writeback.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=7, rt=0 with prior HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO unchanged. Then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0xDEADBEEF issued during MULT busy -> stall=1 every busy cycle, ignored. Re-issued after busy falls -> HI=0xDEADBEEF next edge. MFHI then -> rdata=0xDEADBEEF, stall=0.
